// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime/mtimecmp over a single-outstanding req/ack bus.
// Optional msip register enabled by defining CLINT_MSIP_EN.
module clint_timer #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clint_req,
    input  logic        clint_we,
    input  logic [63:0] clint_addr,
    input  logic [63:0] clint_wdata,
    input  logic [7:0]  clint_wstrb,
    output logic        clint_ack,
    output logic [63:0] clint_rdata,
    output logic        clint_err,
    output logic        clint_mtip,
    output logic        clint_msip
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    localparam logic [12:0] IDX_MSIP     = 13'h0000;
    localparam logic [12:0] IDX_MTIMECMP = 13'h0800;
    localparam logic [12:0] IDX_MTIME    = 13'h17FF;

    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    logic [0:0]  state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        ack_q, ack_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        mtip_q, mtip_d;

    logic [63:0] offset;
    logic        in_range;
    logic        sel_msip;
    logic        sel_mtimecmp;
    logic        sel_mtime;
    logic        hit;
    logic        accept;
    logic        wr_en;
    logic        rd_en;
    logic        tick;
    logic [63:0] mtime_inc;
    logic        unused_lo;

    function automatic logic [63:0] merge_bytes(
        input logic [63:0] old_val,
        input logic [63:0] new_val,
        input logic [7:0]  strb
    );
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // Upper offset bits must be zero so aliases beyond the 64KB window miss.
    assign offset    = clint_addr - BASE_ADDR;
    assign in_range  = (clint_addr >= BASE_ADDR) && (offset[63:16] == 48'h0);
    assign unused_lo = ^offset[2:0];

    assign sel_mtimecmp = in_range && (offset[15:3] == IDX_MTIMECMP);
    assign sel_mtime    = in_range && (offset[15:3] == IDX_MTIME);
`ifdef CLINT_MSIP_EN
    assign sel_msip     = in_range && (offset[15:3] == IDX_MSIP);
`else
    assign sel_msip     = 1'b0;
`endif
    assign hit = sel_msip | sel_mtimecmp | sel_mtime;

    assign accept = (state_q == ST_IDLE) && clint_req;
    assign wr_en  = accept && clint_we;
    assign rd_en  = accept && !clint_we;

    always_comb begin
        state_d = ST_IDLE;
        unique case (state_q)
            ST_IDLE: state_d = clint_req ? ST_RESP : ST_IDLE;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tick    = (presc_q == DIV_LAST);
        presc_d = tick ? 16'h0 : presc_q + 16'h1;
    end

    // Written bytes override the incremented value when a write lands on a tick.
    always_comb begin
        mtime_inc = mtime_q + {63'h0, tick};
        mtime_d   = mtime_inc;
        if (wr_en && sel_mtime) begin
            mtime_d = merge_bytes(mtime_inc, clint_wdata, clint_wstrb);
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (wr_en && sel_mtimecmp) begin
            mtimecmp_d = merge_bytes(mtimecmp_q, clint_wdata, clint_wstrb);
        end
    end

    always_comb begin
        mtip_d = (mtime_d >= mtimecmp_d);
    end

`ifdef CLINT_MSIP_EN
    logic msip_q, msip_d;

    always_comb begin
        msip_d = msip_q;
        if (wr_en && sel_msip && clint_wstrb[0]) begin
            msip_d = clint_wdata[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msip_q <= 1'b0;
        end else begin
            msip_q <= msip_d;
        end
    end

    assign clint_msip = msip_q;
`else
    assign clint_msip = 1'b0;
`endif

    // Read data reflects register state before this cycle's write or tick.
    always_comb begin
        ack_d   = accept;
        err_d   = accept && !hit;
        rdata_d = 64'h0;
        if (rd_en) begin
            if (sel_mtime) begin
                rdata_d = mtime_q;
            end else if (sel_mtimecmp) begin
                rdata_d = mtimecmp_q;
            end
`ifdef CLINT_MSIP_EN
            else if (sel_msip) begin
                rdata_d = {63'h0, msip_q};
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            presc_q    <= 16'h0;
            mtime_q    <= 64'h0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            ack_q      <= 1'b0;
            rdata_q    <= 64'h0;
            err_q      <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            mtip_q     <= mtip_d;
        end
    end

    assign clint_ack   = ack_q;
    assign clint_rdata = rdata_q;
    assign clint_err   = err_q;
    assign clint_mtip  = mtip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: TICK_DIV=1 and TICK_DIV=4 instances share one bus.
// Vector table covers decode/strobe behaviour; hand sequences cover timing corners.
module tb_clint_timer;

    localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
`ifdef CLINT_MSIP_EN
    localparam bit MSIP_ON = 1'b1;
`else
    localparam bit MSIP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req1, req4, we;
    logic [63:0] addr, wdata;
    logic [7:0]  wstrb;
    logic        ack1, err1, mtip1, msip1;
    logic        ack4, err4, mtip4, msip4;
    logic [63:0] rdata1, rdata4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .clint_req(req1), .clint_we(we),
        .clint_addr(addr), .clint_wdata(wdata), .clint_wstrb(wstrb),
        .clint_ack(ack1), .clint_rdata(rdata1), .clint_err(err1),
        .clint_mtip(mtip1), .clint_msip(msip1)
    );

    clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .clint_req(req4), .clint_we(we),
        .clint_addr(addr), .clint_wdata(wdata), .clint_wstrb(wstrb),
        .clint_ack(ack4), .clint_rdata(rdata4), .clint_err(err4),
        .clint_mtip(mtip4), .clint_msip(msip4)
    );

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic access(input bit sel, input logic w, input logic [63:0] a,
                          input logic [63:0] d, input logic [7:0] s,
                          output logic [63:0] rd, output logic er);
        we = w; addr = a; wdata = d; wstrb = s;
        if (sel) req4 = 1'b1; else req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0; req4 = 1'b0;
        chk("ack", sel ? ack4 : ack1, 64'h1);
        rd = sel ? rdata4 : rdata1;
        er = sel ? err4 : err1;
        @(posedge clk); #1;
        chk("ack_drop", sel ? ack4 : ack1, 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        longint      m;
        int          cnt;
        int          c2;

        vecs[0]  = '{1'b1, BASE + 64'h4000, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 1'b0};
        vecs[1]  = '{1'b0, BASE + 64'h4000, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 1'b0};
        vecs[2]  = '{1'b1, BASE + 64'h4000, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 64'h0, 1'b0};
        vecs[3]  = '{1'b0, BASE + 64'h4004, 64'h0, 8'h00, 64'h1122_3344_CAFE_F00D, 1'b0};
        vecs[4]  = '{1'b1, BASE + 64'h4000, 64'h0, 8'h00, 64'h0, 1'b0};
        vecs[5]  = '{1'b0, BASE + 64'h4000, 64'h0, 8'h00, 64'h1122_3344_CAFE_F00D, 1'b0};
        vecs[6]  = '{1'b0, BASE + 64'h8000, 64'h0, 8'h00, 64'h0, 1'b1};
        vecs[7]  = '{1'b1, BASE + 64'h8000, 64'h5555, 8'hFF, 64'h0, 1'b1};
        vecs[8]  = '{1'b0, BASE - 64'h8, 64'h0, 8'h00, 64'h0, 1'b1};
        vecs[9]  = '{1'b1, BASE - 64'h8, 64'h0, 8'hFF, 64'h0, 1'b1};
        vecs[10] = '{1'b0, BASE + 64'h1_4000, 64'h0, 8'h00, 64'h0, 1'b1};
        vecs[11] = '{1'b1, BASE + 64'h1_4000, 64'h0, 8'hFF, 64'h0, 1'b1};
        vecs[12] = '{1'b0, BASE + 64'h4000, 64'h0, 8'h00, 64'h1122_3344_CAFE_F00D, 1'b0};
        vecs[13] = '{1'b0, BASE, 64'h0, 8'h00, 64'h0, !MSIP_ON};
        vecs[14] = '{1'b1, BASE, 64'hFFFF, 8'hFF, 64'h0, !MSIP_ON};
        vecs[15] = '{1'b0, BASE, 64'h0, 8'h00, {63'h0, MSIP_ON}, !MSIP_ON};

        req1 = 1'b0; req4 = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; wstrb = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack1, 64'h0);
        chk("rst_rdata", rdata1, 64'h0);
        chk("rst_err", err1, 64'h0);
        chk("rst_mtip", mtip1, 64'h0);
        chk("rst_msip", msip1, 64'h0);
        chk("rst_mtip4", mtip4, 64'h0);
        rst = 1'b0;

        repeat (10) @(posedge clk);
        #1;
        access(1'b0, 1'b0, BASE + 64'hBFF8, 64'h0, 8'h00, rd, er);
        chk("t1_rdata", rd, 64'd10);
        chk("t1_err", er, 64'h0);

        access(1'b0, 1'b1, BASE + 64'h4000, 64'd20, 8'hFF, rd, er);
        access(1'b0, 1'b1, BASE + 64'hBFF8, 64'd5, 8'hFF, rd, er);
        access(1'b0, 1'b0, BASE + 64'hBFF8, 64'h0, 8'h00, rd, er);
        chk("t2_mtime", rd, 64'd6);
        m = 8;
        chk("t2_mtip_lo", mtip1, 64'h0);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            m++;
            chk($sformatf("t2_mtip_m%0d", m), mtip1, (m >= 20) ? 64'h1 : 64'h0);
        end

        we = 1'b1; addr = BASE + 64'h4000;
        wdata = 64'hFFFF_FFFF_FFFF_FFFF; wstrb = 8'hFF;
        req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
        chk("t2_clr_ack", ack1, 64'h1);
        chk("t2_clr_mtip", mtip1, 64'h0);
        @(posedge clk); #1;

        access(1'b0, 1'b1, BASE + 64'hBFF8, 64'h1FE, 8'hFF, rd, er);
        access(1'b0, 1'b1, BASE + 64'hBFF8, 64'hAA, 8'h01, rd, er);
        chk("t4_err", er, 64'h0);
        access(1'b0, 1'b0, BASE + 64'hBFF8, 64'h0, 8'h00, rd, er);
        chk("t4_mtime", rd, 64'h2AB);

        for (int i = 0; i < 16; i++) begin
            access(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].wstrb, rd, er);
            chk($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
            if (!vecs[i].we) begin
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            end
        end
        chk("msip_out", msip1, MSIP_ON);
        chk("msip4_out", msip4, 64'h0);

        access(1'b1, 1'b1, BASE + 64'h4000, 64'd1, 8'hFF, rd, er);
        access(1'b1, 1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er);
        chk("t3_mtip_hi", mtip4, 64'h1);
        cnt = 1;
        while (mtip4 === 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("t3_wrap_drop", mtip4, 64'h0);
        chk("t3_wrap_lat_ok", (cnt >= 5 && cnt <= 8) ? 64'h1 : 64'h0, 64'h1);
        c2 = 0;
        while (mtip4 === 1'b0 && c2 < 20) begin
            @(posedge clk); #1;
            c2++;
        end
        chk("t3_rise_cycles", 64'(c2), 64'd4);
        access(1'b1, 1'b0, BASE + 64'hBFF8, 64'h0, 8'h00, rd, er);
        chk("t3_mtime", rd, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
